// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame packer.
// Holds the controller state encoding so that the top level and any future
// observers (status decoders, debug taps) agree on what IDLE and RUN mean.
// Parameters stay local to each module that uses them.
package axis_pkg;

  // Frame controller states.
  //   IDLE : not forwarding; upstream is held off (s_axis_tready low).
  //   RUN  : forwarding words and counting them into frames of length L.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with fully registered outputs.
//
// Entry p0 drives the output port directly. Entry p1 catches the word that
// arrives in the cycle when the output stalls. Because s_ready depends only
// on p1 being empty, the upstream handshake never looks at the same-cycle
// m_ready, and the buffer still sustains one word per clock.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   s_data/s_valid    : upstream word and its valid
//   s_ready           : high while the catch entry is empty
//   m_data/m_valid    : registered downstream word and its valid
//   m_ready           : downstream accept
module axis_skid_buffer #(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready
);

  logic [DATA_W-1:0] data_p0;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p0;
  logic              vld_p1;
  logic              s_fire;
  logic              slot_free;

  assign s_ready   = ~vld_p1;
  assign s_fire    = s_valid & s_ready;
  // The output entry can take a new word when it is empty or being consumed.
  assign slot_free = m_ready | ~vld_p0;

  // Output stage (p0): the output data is cleared on reset so the port is
  // quiet (all zero) while the block is held in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      data_p0 <= '0;
    end else if (slot_free) begin
      if (vld_p1) begin
        // Older word waiting in the catch entry goes out first. s_ready was
        // low this cycle, so no new word can arrive alongside it.
        data_p0 <= data_p1;
        vld_p0  <= 1'b1;
        vld_p1  <= 1'b0;
      end else begin
        vld_p0 <= s_fire;
        if (s_fire) begin
          data_p0 <= s_data;
        end
      end
    end else if (s_fire) begin
      vld_p1 <= 1'b1;
    end
  end

  // Catch stage (p1): captures the word that arrives while p0 is stalled.
  // Its contents are meaningless while vld_p1 is low, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!slot_free && s_fire) begin
      data_p1 <= s_data;
    end
  end

  assign m_data  = data_p0;
  assign m_valid = vld_p0;

endmodule

// File: rtl/axis_frame_packer.sv
// AXI-Stream frame packer.
//
// Forwards words from the upstream stream to the downstream stream, marking
// every L-th word with tlast, where L is taken from cfg_data when a frame
// starts. cfg_enable gates the start of each new frame; a frame already in
// progress always runs to completion. sts_data counts completed frames.
//
// Ports
//   aclk, areset                 : clock, synchronous active-high reset
//   cfg_enable                   : allow new frames to start
//   cfg_data [CNTR_WIDTH]        : words per frame (0 means do not start)
//   s_axis_tdata/tvalid/tready   : upstream stream
//   m_axis_tdata/tvalid/tready/tlast : framed downstream stream (registered)
//   sts_data [STS_WIDTH]         : frames completed since reset (wraps)
module axis_frame_packer
  import axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 16,
  parameter int STS_WIDTH        = 32
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        cfg_enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_data,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  output logic [STS_WIDTH-1:0]        sts_data
);

  localparam int BUF_W = AXIS_TDATA_WIDTH + 1;

  state_t                  state;
  logic [CNTR_WIDTH-1:0]   len;
  logic [CNTR_WIDTH-1:0]   cnt;
  logic [STS_WIDTH-1:0]    frames;

  logic                    buf_ready;
  logic                    accept;
  logic                    frame_end;
  logic                    cfg_ok;
  logic [BUF_W-1:0]        buf_in;
  logic [BUF_W-1:0]        buf_out;

  assign cfg_ok    = cfg_enable && (cfg_data != '0);
  assign s_axis_tready = (state == RUN) && buf_ready;
  assign accept    = s_axis_tvalid && s_axis_tready;
  // len is never zero in RUN, so len-1 cannot wrap; the largest count
  // reached is 2^CNTR_WIDTH-2, which fits the counter.
  assign frame_end = (cnt == len - CNTR_WIDTH'(1));

  // Frame controller: counts accepted words, tags the last word of each
  // frame and decides at every frame boundary whether to keep running.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      len    <= '0;
      cnt    <= '0;
      frames <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_ok) begin
            state <= RUN;
            len   <= cfg_data;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (frame_end) begin
              cnt    <= '0;
              frames <= frames + STS_WIDTH'(1);
              // Back-to-back frames when still enabled; the new length is
              // picked up only here, never in the middle of a frame.
              if (cfg_ok) begin
                len <= cfg_data;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CNTR_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sts_data = frames;

  // tlast travels with its word through the buffer as the top bit.
  assign buf_in = {frame_end, s_axis_tdata};

  axis_skid_buffer #(
    .DATA_W (BUF_W)
  ) u_skid (
    .clk     (aclk),
    .rst     (areset),
    .s_data  (buf_in),
    .s_valid (accept),
    .s_ready (buf_ready),
    .m_data  (buf_out),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

  assign m_axis_tlast = buf_out[BUF_W-1];
  assign m_axis_tdata = buf_out[AXIS_TDATA_WIDTH-1:0];

endmodule

// File: tb/tb_axis_frame_packer.sv
// Bench for axis_frame_packer: table-driven frame runs with random data and
// optional random downstream backpressure, hand-written sequences for
// configuration changes, graceful stop, zero length and mid-frame reset,
// plus a narrow-counter instance exercising the maximum frame length.
module tb_axis_frame_packer;

  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int SW  = 32;
  localparam int SDW = 8;
  localparam int SCW = 3;
  localparam int SSW = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cfg_enable = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic [W-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic [SW-1:0] sts;

  logic           sm_cfg_enable = 1'b0;
  logic [SCW-1:0] sm_cfg_data = '0;
  logic [SDW-1:0] sm_s_tdata = '0;
  logic           sm_s_tvalid = 1'b0;
  logic           sm_s_tready;
  logic [SDW-1:0] sm_m_tdata;
  logic           sm_m_tvalid;
  logic           sm_m_tready = 1'b1;
  logic           sm_m_tlast;
  logic [SSW-1:0] sm_sts;

  always #5 aclk = ~aclk;

  axis_frame_packer #(
    .AXIS_TDATA_WIDTH (W),
    .CNTR_WIDTH       (CW),
    .STS_WIDTH        (SW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_enable    (cfg_enable),
    .cfg_data      (cfg_data),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .sts_data      (sts)
  );

  axis_frame_packer #(
    .AXIS_TDATA_WIDTH (SDW),
    .CNTR_WIDTH       (SCW),
    .STS_WIDTH        (SSW)
  ) dut_small (
    .aclk          (aclk),
    .areset        (areset),
    .cfg_enable    (sm_cfg_enable),
    .cfg_data      (sm_cfg_data),
    .s_axis_tdata  (sm_s_tdata),
    .s_axis_tvalid (sm_s_tvalid),
    .s_axis_tready (sm_s_tready),
    .m_axis_tdata  (sm_m_tdata),
    .m_axis_tvalid (sm_m_tvalid),
    .m_axis_tready (sm_m_tready),
    .m_axis_tlast  (sm_m_tlast),
    .sts_data      (sm_sts)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } word_t;

  typedef struct {
    int len;
    int nwords;
    bit rr;
    int frames;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  word_t  q[$];
  logic   prev_stall = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic   prev_l = 1'b0;
  logic   took = 1'b0;
  logic   cur_last = 1'b0;
  bit     rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: observe both streams at the falling edge, then move to just
  // after the rising edge where new stimulus is applied.
  task automatic tick();
    word_t e;
    @(negedge aclk);
    if (prev_stall) begin
      check("hold_valid", 64'(m_tvalid), 64'(1));
      check("hold_data", 64'(m_tdata), 64'(prev_d));
      check("hold_last", 64'(m_tlast), 64'(prev_l));
    end
    if (m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data=%0h last=%0b with nothing expected", m_tdata, m_tlast);
      end else begin
        e = q.pop_front();
        check("out_data", 64'(m_tdata), 64'(e.d));
        check("out_last", 64'(m_tlast), 64'(e.l));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_d     = m_tdata;
    prev_l     = m_tlast;
    took       = s_tvalid && s_tready;
    if (took) begin
      e.d = s_tdata;
      e.l = cur_last;
      q.push_back(e);
    end
    @(posedge aclk);
    #1;
    if (rand_ready) m_tready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic [W-1:0] d, input logic last, inout int cyc);
    s_tdata  = d;
    s_tvalid = 1'b1;
    cur_last = last;
    for (int n = 0; n < 100; n++) begin
      tick();
      cyc++;
      if (took) break;
    end
    check("send_accepted", 64'(took), 64'(1));
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    for (int n = 0; n < 100 && q.size() != 0; n++) tick();
    tick();
    tick();
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    cfg_enable    = 1'b0;
    s_tvalid      = 1'b0;
    sm_cfg_enable = 1'b0;
    sm_s_tvalid   = 1'b0;
    rand_ready    = 1'b0;
    m_tready      = 1'b1;
    prev_stall    = 1'b0;
    tick();
    tick();
    q.delete();
    prev_stall = 1'b0;
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tlast", 64'(m_tlast), 64'(0));
    check("rst_tdata", 64'(m_tdata), 64'(0));
    check("rst_tready", 64'(s_tready), 64'(0));
    check("rst_sts", 64'(sts), 64'(0));
    check("rst_small_tvalid", 64'(sm_m_tvalid), 64'(0));
    areset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vt[5];
    int         cyc;
    bit [8:0]   lasts;
    int         nlast;
    logic       adv;

    vt[0] = '{len: 4, nwords: 12, rr: 1'b0, frames: 3};
    vt[1] = '{len: 3, nwords: 30, rr: 1'b1, frames: 10};
    vt[2] = '{len: 1, nwords: 6,  rr: 1'b1, frames: 6};
    vt[3] = '{len: 7, nwords: 20, rr: 1'b1, frames: 2};
    vt[4] = '{len: 2, nwords: 9,  rr: 1'b0, frames: 4};

    @(posedge aclk);
    #1;

    // Table-driven frame runs: tlast on every len-th word counted from 0.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cfg_enable = 1'b1;
      cfg_data   = CW'(vt[v].len);
      tick();
      rand_ready = vt[v].rr;
      cyc = 0;
      for (int i = 0; i < vt[v].nwords; i++) begin
        send(W'($urandom), (i % vt[v].len) == vt[v].len - 1, cyc);
      end
      if (!vt[v].rr) check("no_bubble_cycles", 64'(cyc), 64'(vt[v].nwords));
      rand_ready = 1'b0;
      m_tready   = 1'b1;
      drain();
      check("sts_frames", 64'(sts), 64'(vt[v].frames));
    end

    // Length change mid-frame: first frame keeps 5 words, then frames of 2.
    do_reset();
    cfg_enable = 1'b1;
    cfg_data   = CW'(5);
    tick();
    cyc   = 0;
    lasts = 9'b101010000;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) cfg_data = CW'(2);
      send(W'(100 + i), lasts[i], cyc);
    end
    drain();
    check("cfg_change_sts", 64'(sts), 64'(3));

    // Graceful stop: enable dropped after word 1, frame still completes.
    do_reset();
    cfg_enable = 1'b1;
    cfg_data   = CW'(4);
    tick();
    cyc = 0;
    send(W'(200), 1'b0, cyc);
    send(W'(201), 1'b0, cyc);
    cfg_enable = 1'b0;
    send(W'(202), 1'b0, cyc);
    send(W'(203), 1'b1, cyc);
    check("stop_tready", 64'(s_tready), 64'(0));
    s_tdata  = W'(204);
    s_tvalid = 1'b1;
    cur_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stop_no_accept", 64'(took), 64'(0));
    end
    drain();
    check("stop_sts", 64'(sts), 64'(1));

    // Zero length: stays idle and refuses words.
    do_reset();
    cfg_enable = 1'b1;
    cfg_data   = '0;
    s_tdata    = W'(300);
    s_tvalid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("zero_len_tready", 64'(s_tready), 64'(0));
      check("zero_len_no_accept", 64'(took), 64'(0));
    end
    s_tvalid = 1'b0;
    check("zero_len_tvalid", 64'(m_tvalid), 64'(0));

    // Reset in the middle of an 8-word frame.
    do_reset();
    cfg_enable = 1'b1;
    cfg_data   = CW'(8);
    tick();
    cyc = 0;
    for (int i = 0; i < 3; i++) send(W'(400 + i), 1'b0, cyc);
    areset   = 1'b1;
    s_tvalid = 1'b0;
    tick();
    check("midrst_tvalid", 64'(m_tvalid), 64'(0));
    check("midrst_tlast", 64'(m_tlast), 64'(0));
    check("midrst_sts", 64'(sts), 64'(0));
    q.delete();
    prev_stall = 1'b0;
    areset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) send(W'(500 + i), i == 7, cyc);
    drain();
    check("midrst_restart_sts", 64'(sts), 64'(1));

    // Maximum length on a 3-bit counter: L=7, tlast on data 6, 13, ...
    do_reset();
    sm_cfg_enable = 1'b1;
    sm_cfg_data   = SCW'(7);
    sm_m_tready   = 1'b1;
    sm_s_tdata    = '0;
    sm_s_tvalid   = 1'b1;
    nlast = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge aclk);
      if (sm_m_tvalid) begin
        check("maxlen_last", 64'(sm_m_tlast), 64'((sm_m_tdata % SDW'(7)) == SDW'(6)));
        if (sm_m_tlast) nlast++;
      end
      adv = sm_s_tvalid && sm_s_tready;
      @(posedge aclk);
      #1;
      if (adv) sm_s_tdata = sm_s_tdata + SDW'(1);
    end
    sm_s_tvalid = 1'b0;
    check("maxlen_words", 64'(sm_s_tdata), 64'(19));
    check("maxlen_tlast_count", 64'(nlast), 64'(2));
    check("maxlen_sts", 64'(sm_sts), 64'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_frame_packer.md
AXIS_FRAME_PACKER -- requirements
Module: axis_frame_packer

Interface
REQ-001 Parameter AXIS_TDATA_WIDTH, default 32, SHALL set the data width of the slave and master streams.
REQ-002 Parameter CNTR_WIDTH, default 16, SHALL set the width of the frame-length config and the word counter.
REQ-003 Parameter STS_WIDTH, default 32, SHALL set the width of the frame-count status.
REQ-004 aclk  input  1  SHALL be the single clock for all logic.
REQ-005 areset  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 cfg_enable  input  1  SHALL enable frame forwarding when high.
REQ-007 cfg_data  input  CNTR_WIDTH  SHALL give the number of words per frame.
REQ-008 s_axis_tdata/s_axis_tvalid/s_axis_tready  in/in/out  AXIS_TDATA_WIDTH/1/1  SHALL be the upstream stream, fed by the selector output.
REQ-009 m_axis_tdata/m_axis_tvalid/m_axis_tready/m_axis_tlast  out/out/in/out  AXIS_TDATA_WIDTH/1/1/1  SHALL be the framed downstream stream.
REQ-010 sts_data  output  STS_WIDTH  SHALL report the number of frames completed since reset.

Function
REQ-011 States SHALL be IDLE and RUN.
REQ-012 IDLE->RUN SHALL occur on a cycle with cfg_enable=1 and cfg_data!=0, latching cfg_data as the frame length L.
REQ-013 In IDLE, s_axis_tready SHALL be 0 and no word SHALL be accepted.
REQ-014 In RUN, a word SHALL be accepted only on a cycle with s_axis_tvalid & s_axis_tready.
REQ-015 In RUN, each accepted word SHALL increment the word counter.
REQ-016 The word accepted when counter==L-1 SHALL carry tlast=1, reset the counter to 0, and increment sts_data (modulo 2^STS_WIDTH).
REQ-017 At a frame end with cfg_enable=1 and cfg_data!=0, the block SHALL relatch L from cfg_data and stay in RUN with no bubble.
REQ-018 At a frame end otherwise, the block SHALL go to IDLE.
REQ-019 Changes to cfg_data mid-frame SHALL NOT affect the current frame.
REQ-020 Deassertion of cfg_enable mid-frame SHALL let the current frame complete (graceful stop).
REQ-021 L=1 SHALL mark every word tlast=1.
REQ-022 L=2^CNTR_WIDTH-1 SHALL be supported without counter overflow.
REQ-023 The output SHALL be registered: an accepted word SHALL appear on m_axis with 1-cycle latency.
REQ-024 A 2-entry skid buffer SHALL sustain 1 word/cycle with s_axis_tready independent of the same-cycle m_axis_tready.
REQ-025 Once asserted, m_axis_tvalid SHALL hold, with tdata and tlast stable, until m_axis_tready=1.
REQ-026 Words SHALL be neither dropped nor duplicated under any backpressure pattern.
REQ-027 In RUN, s_axis_tready SHALL be 0 only while the skid buffer is full.

Reset
REQ-028 While areset=1 at a clock edge: state=IDLE, counter=0, L=0, skid buffer empty, sts_data=0.
REQ-029 While areset=1 at a clock edge: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame and buffered words, with no tlast emitted for it.

Structure
REQ-031 The IDLE/RUN encodings SHALL be defined in the shared package axis_pkg; the parameters SHALL remain module-local.
REQ-032 The skid buffer SHALL be a sub-module named axis_skid_buffer (data+tlast width, valid/ready both sides, synchronous active-high reset).
REQ-033 The target implementation size SHALL be 120-400 RTL lines.

Verification
REQ-034 Bench: L=4, enable=1, continuous valid, ready=1, words 0..11 -> tlast on words 3, 7, 11; sts_data=3; no idle cycles.
REQ-035 Bench: L=3, random m_axis_tready at 50% -> output sequence equals input, tlast on every 3rd word, tvalid/tdata stable while stalled.
REQ-036 Bench: L=5, cfg_data changed to 2 after word 1 -> first frame has 5 words, next frames have 2 words.
REQ-037 Bench: L=4, cfg_enable dropped after word 1 -> words 2..3 still forwarded, tlast on word 3, then s_axis_tready=0.
REQ-038 Bench: L=1 and cfg_data=0 cases -> L=1 gives tlast on every word; cfg_data=0 keeps IDLE with tready=0.
REQ-039 Bench: areset pulsed after word 2 of L=8 -> m_axis_tvalid=0 next cycle, sts_data=0, next frame restarts counting at word 0.
